mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the fetch stage (read-only) and the memory stage (load/store).
- Data requests have priority by default. A starvation guard forces a fetch grant after MAX_WAIT consecutive lost arbitrations.
- A fetch flush (taken branch) suppresses delivery of an in-flight fetch.
- Sits between the pipeline stage logic and the memory array/controller.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_priority_sel.sv | 25 ++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_AW     = 10;
  localparam int unsigned MEM_ARB_DW     = 32;
  localparam int unsigned MEM_ARB_WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational pick between fetch and data requesters; data wins unless fetch is starved.
module arb_priority_sel
  import mem_arb_pkg::*;
(
  input  logic if_elig,
  input  logic dm_elig,
  input  logic starved,
  output logic grant_if,
  output logic grant_dm
);

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (if_elig && dm_elig) begin
      if (starved) grant_if = 1'b1;
      else         grant_dm = 1'b1;
    end else if (if_elig) begin
      grant_if = 1'b1;
    end else if (dm_elig) begin
      grant_dm = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch (read-only) and load/store requesters.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = MEM_ARB_AW,
  parameter int unsigned DW       = MEM_ARB_DW,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_conflicts,
  output logic [15:0]   perf_if_stall,
  output logic [15:0]   perf_forced
`endif
);

  localparam logic [MEM_ARB_WAIT_W-1:0] MAX_WAIT_C = MEM_ARB_WAIT_W'(MAX_WAIT);

  arb_state_t                state;
  logic [MEM_ARB_WAIT_W-1:0] wait_cnt;
  logic                      drop;
  logic                      idle;
  logic                      if_elig;
  logic                      dm_elig;
  logic                      starved;
  logic                      conflict;
  logic                      grant_if;
  logic                      grant_dm;

  // A requester still shows req during its own ack cycle; that stale level is not a new request.
  assign idle     = (state == IDLE);
  assign if_elig  = idle && if_req && !if_ack;
  assign dm_elig  = idle && dm_req && !dm_ack;
  assign starved  = (wait_cnt >= MAX_WAIT_C);
  assign conflict = if_elig && dm_elig;

  arb_priority_sel u_sel (
    .if_elig  (if_elig),
    .dm_elig  (dm_elig),
    .starved  (starved),
    .grant_if (grant_if),
    .grant_dm (grant_dm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      drop      <= 1'b0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_ack    <= 1'b0;
      dm_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            state     <= BUSY_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            drop      <= if_flush;
          end else if (grant_dm) begin
            state     <= BUSY_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (conflict) wait_cnt <= wait_cnt + 1'b1;
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            drop    <= 1'b0;
            // A flush arriving with the completion still cancels delivery.
            if (!(drop || if_flush)) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (if_flush) begin
            drop <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            dm_ack  <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic forced;
  assign forced = conflict && starved;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflicts <= '0;
      perf_if_stall  <= '0;
      perf_forced    <= '0;
    end else begin
      if (conflict)          perf_conflicts <= sat_inc16(perf_conflicts);
      if (if_req && !if_ack) perf_if_stall  <= sat_inc16(perf_if_stall);
      if (forced)            perf_forced    <= sat_inc16(perf_forced);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run against a shadow-memory model.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_flush, if_ack;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_ack;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] rmem    [1024];
  logic [DW-1:0] ref_mem [1024];
  int   lat_min = 1;
  int   lat_max = 1;
  logic stray_ready = 1'b0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory responder: answers mem_req after a latency of lat_min..lat_max cycles.
  initial begin : responder
    int cnt;
    int lat;
    cnt = 0; lat = 1; mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !mem_req) begin
        cnt = 0; mem_ready = stray_ready; mem_rdata = $urandom;
      end else begin
        if (cnt == 0) lat = lat_min + $urandom_range(0, lat_max - lat_min);
        cnt++;
        if (cnt >= lat) begin
          mem_ready = 1'b1;
          if (mem_we) begin rmem[mem_addr] = mem_wdata; mem_rdata = $urandom; end
          else mem_rdata = rmem[mem_addr];
        end else begin
          mem_ready = 1'b0; mem_rdata = $urandom;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_req = 0; if_flush = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 0; if_flush = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      rmem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
      ref_mem[i] = rmem[i];
    end
    step(); step();
    n_checks++;
    if ({if_ack, dm_ack, mem_req, mem_we} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {if_ack, dm_ack, mem_req, mem_we});
    end
    n_checks++;
    if ({if_rdata, dm_rdata, mem_wdata, mem_addr} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h expected all 0", if_rdata, dm_rdata, mem_wdata, mem_addr);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    rmem[5] = 32'h2842000A; ref_mem[5] = 32'h2842000A;
    lat_min = 1; lat_max = 1;
    if_addr = 10'h005; if_req = 1;
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'h005 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL single_fetch_mem: got req=%b addr=%h we=%b expected 1/005/0", mem_req, mem_addr, mem_we);
    end
    step();
    n_checks++;
    if (if_ack !== 1'b1) begin n_fail++; $display("FAIL single_fetch_ack: got %b expected 1", if_ack); end
    n_checks++;
    if (if_rdata !== 32'h2842000A) begin n_fail++; $display("FAIL single_fetch_data: got %h expected 2842000a", if_rdata); end
    step();
    n_checks++;
    if (if_ack !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL single_fetch_ack_cycle_ignored: got ack=%b req=%b expected 0/0", if_ack, mem_req);
    end
    if_req = 0;
    step();
  endtask

  task automatic test_store_load();
    logic [DW-1:0] prev;
    bit got;
    prev = dm_rdata;
    dm_we = 1; dm_addr = 10'h0C8; dm_wdata = 32'h55; dm_req = 1;
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h0C8 || mem_wdata !== 32'h55) begin
      n_fail++; $display("FAIL store_mem: got req=%b we=%b addr=%h wdata=%h expected 1/1/0c8/55", mem_req, mem_we, mem_addr, mem_wdata);
    end
    step();
    n_checks++;
    if (dm_ack !== 1'b1) begin n_fail++; $display("FAIL store_ack: got %b expected 1", dm_ack); end
    n_checks++;
    if (dm_rdata !== prev) begin n_fail++; $display("FAIL store_rdata_hold: got %h expected %h", dm_rdata, prev); end
    ref_mem[10'h0C8] = 32'h55;
    step();
    dm_req = 0; dm_we = 0; dm_wdata = $urandom;
    step();
    dm_req = 1;
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h0C8) begin
      n_fail++; $display("FAIL load_mem: got req=%b we=%b addr=%h expected 1/0/0c8", mem_req, mem_we, mem_addr);
    end
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      if (dm_ack) got = 1;
    end
    n_checks++;
    if (!got || dm_rdata !== 32'h55) begin
      n_fail++; $display("FAIL load_data: got ack=%b data=%h expected 1/00000055", got, dm_rdata);
    end
    step();
    dm_req = 0;
    step();
  endtask

  // Both requesters held high: a grant is made in every ack cycle to the other side.
  task automatic test_contention();
    int ng, kind;
    int exp_kind[6];
    logic prev;
    exp_kind = '{1, 0, 1, 0, 1, 0};
    lat_min = 1; lat_max = 1;
    if_addr = 10'h100; dm_addr = 10'h200; dm_we = 0; if_req = 1; dm_req = 1;
    ng = 0; prev = 0;
    for (int c = 1; c <= 30 && ng < 6; c++) begin
      step();
      if (mem_req && !prev) begin
        kind = (mem_addr == 10'h200) ? 1 : 0;
        n_checks++;
        if (kind != exp_kind[ng] || c != 2 * ng + 1) begin
          n_fail++; $display("FAIL contention_grant%0d: got kind=%0d cycle=%0d expected kind=%0d cycle=%0d",
                             ng, kind, c, exp_kind[ng], 2 * ng + 1);
        end
        ng++;
      end
      prev = mem_req;
    end
    n_checks++;
    if (ng != 6) begin n_fail++; $display("FAIL contention_count: got %0d grants expected 6", ng); end
    if_req = 0; dm_req = 0;
    repeat (4) step();
  endtask

  task automatic test_starvation();
    int losses, exp_kind, kind;
    bit pif, pdm, drop_if, drop_dm;
    do_reset();
    lat_min = 1; lat_max = 1;
    losses = 0;
    for (int r = 0; r < 7; r++) begin
      exp_kind = (losses < 4) ? 1 : 0;
      if (exp_kind == 1) losses++;
      else losses = 0;
      if_addr = 10'h100; dm_addr = 10'h200; dm_we = 0; if_req = 1; dm_req = 1;
      step();
      kind = !mem_req ? 2 : (mem_addr == 10'h200) ? 1 : 0;
      n_checks++;
      if (kind != exp_kind) begin
        n_fail++; $display("FAIL starvation_round%0d: got kind=%0d expected %0d", r, kind, exp_kind);
      end
      pdm = 1; pif = 1;
      if (kind == 1) begin if_req = 0; pif = 0; end
      drop_if = 0; drop_dm = 0;
      for (int c = 0; c < 20 && (pif || pdm || drop_if || drop_dm); c++) begin
        step();
        if (drop_if) begin if_req = 0; drop_if = 0; end
        if (drop_dm) begin dm_req = 0; drop_dm = 0; end
        if (if_ack) begin pif = 0; drop_if = 1; end
        if (dm_ack) begin pdm = 0; drop_dm = 1; end
      end
      if (pif || pdm) begin
        n_checks++; n_fail++;
        $display("FAIL starvation_timeout%0d: got pending if=%b dm=%b expected none", r, pif, pdm);
      end
      if_req = 0; dm_req = 0;
      step();
    end
  endtask

  task automatic test_flush();
    int acks;
    bit got;
    lat_min = 3; lat_max = 3;
    if_addr = 10'h010; if_req = 1;
    step();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'h010) begin
      n_fail++; $display("FAIL flush_busy_grant: got req=%b addr=%h expected 1/010", mem_req, mem_addr);
    end
    if_flush = 1;
    step();
    if_flush = 0; if_req = 0;
    dm_addr = 10'h020; dm_we = 0; dm_req = 1;
    acks = 0; got = 0;
    for (int c = 0; c < 14 && !got; c++) begin
      step();
      if (if_ack) acks++;
      if (dm_ack) got = 1;
    end
    n_checks++;
    if (acks != 0) begin n_fail++; $display("FAIL flush_busy_no_ack: got %0d if_acks expected 0", acks); end
    n_checks++;
    if (!got || dm_rdata !== ref_mem[10'h020]) begin
      n_fail++; $display("FAIL flush_then_dm: got ack=%b data=%h expected 1/%h", got, dm_rdata, ref_mem[10'h020]);
    end
    step();
    dm_req = 0;
    step();
    // flush coincident with completion
    lat_min = 2; lat_max = 2;
    if_addr = 10'h011; if_req = 1;
    step(); step();
    if_flush = 1;
    step();
    if_flush = 0; if_req = 0;
    n_checks++;
    if (if_ack !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL flush_with_ready: got ack=%b req=%b expected 0/0", if_ack, mem_req);
    end
    step(); step();
    // flush in IDLE without a grant is ignored
    lat_min = 1; lat_max = 1;
    if_flush = 1;
    step();
    if_flush = 0; if_addr = 10'h012; if_req = 1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      if (if_ack) got = 1;
    end
    n_checks++;
    if (!got || if_rdata !== ref_mem[10'h012]) begin
      n_fail++; $display("FAIL flush_idle_noeffect: got ack=%b data=%h expected 1/%h", got, if_rdata, ref_mem[10'h012]);
    end
    step();
    if_req = 0;
    step();
    // flush in the grant cycle
    if_addr = 10'h013; if_req = 1; if_flush = 1;
    step();
    if_flush = 0; if_req = 0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'h013) begin
      n_fail++; $display("FAIL flush_grant_access: got req=%b addr=%h expected 1/013", mem_req, mem_addr);
    end
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (if_ack) acks++;
    end
    n_checks++;
    if (acks != 0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL flush_grant_no_ack: got acks=%0d req=%b expected 0/0", acks, mem_req);
    end
  endtask

  task automatic test_wait_states();
    bit got;
    lat_min = 6; lat_max = 6;
    dm_addr = 10'h030; dm_we = 0; dm_req = 1;
    step();
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 10'h030 || mem_we !== 1'b0 || dm_ack !== 1'b0) begin
        n_fail++; $display("FAIL wait_stable_c%0d: got req=%b addr=%h we=%b ack=%b expected 1/030/0/0",
                           k, mem_req, mem_addr, mem_we, dm_ack);
      end
      if (k == 1) begin if_addr = 10'h031; if_req = 1; end
      step();
    end
    step();
    n_checks++;
    if (dm_ack !== 1'b1 || dm_rdata !== ref_mem[10'h030]) begin
      n_fail++; $display("FAIL wait_ack: got ack=%b data=%h expected 1/%h", dm_ack, dm_rdata, ref_mem[10'h030]);
    end
    step();
    dm_req = 0;
    n_checks++;
    if (dm_ack !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 10'h031) begin
      n_fail++; $display("FAIL wait_next_grant: got ack=%b req=%b addr=%h expected 0/1/031", dm_ack, mem_req, mem_addr);
    end
    got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      step();
      if (if_ack) got = 1;
    end
    n_checks++;
    if (!got || if_rdata !== ref_mem[10'h031]) begin
      n_fail++; $display("FAIL wait_if_data: got ack=%b data=%h expected 1/%h", got, if_rdata, ref_mem[10'h031]);
    end
    step();
    if_req = 0;
    step();
  endtask

  task automatic test_stray_ready();
    stray_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (mem_req !== 1'b0 || if_ack !== 1'b0 || dm_ack !== 1'b0) begin
        n_fail++; $display("FAIL stray_ready_c%0d: got req=%b if_ack=%b dm_ack=%b expected 0/0/0", k, mem_req, if_ack, dm_ack);
      end
    end
    stray_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bit got;
    lat_min = 10; lat_max = 10;
    dm_addr = 10'h040; dm_we = 0; dm_req = 1;
    step(); step(); step();
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL reset_mid_busy: got req=%b expected 1", mem_req); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_we, if_ack, dm_ack} !== 4'b0 || {mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got req=%b addr=%h rdata=%h/%h expected all 0",
                         mem_req, mem_addr, if_rdata, dm_rdata);
    end
    dm_req = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    lat_min = 1; lat_max = 1;
    if_addr = 10'h041; if_req = 1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      if (if_ack) got = 1;
    end
    n_checks++;
    if (!got || if_rdata !== ref_mem[10'h041]) begin
      n_fail++; $display("FAIL reset_mid_recover: got ack=%b data=%h expected 1/%h", got, if_rdata, ref_mem[10'h041]);
    end
    step();
    if_req = 0;
    step();
  endtask

  task automatic test_random();
    bit if_pend, dm_pend, if_ackd, dm_ackd, m_if, m_dm;
    logic [AW-1:0] if_cur, dm_cur, prev_addr;
    logic dm_cur_we, prev_req, prev_ready;
    logic [DW-1:0] dm_cur_wdata, prev_dm_rdata;
    int if_age, dm_age, if_done, dm_done;
    if_pend = 0; dm_pend = 0; if_ackd = 0; dm_ackd = 0;
    if_age = 0; dm_age = 0; if_done = 0; dm_done = 0;
    if_cur = '0; dm_cur = '0; dm_cur_we = 0; dm_cur_wdata = '0;
    prev_req = 0; prev_ready = 0; prev_addr = '0; prev_dm_rdata = dm_rdata;
    lat_min = 1; lat_max = 4;
    for (int cyc = 0; cyc < 1300; cyc++) begin
      step();
      if (if_ackd) begin if_req = 0; if_ackd = 0; end
      if (dm_ackd) begin dm_req = 0; dm_ackd = 0; end
      if (if_ack || dm_ack) begin
        n_checks++;
        if (if_ack && dm_ack) begin n_fail++; $display("FAIL rnd_dual_ack: cycle %0d got both acks expected one", cyc); end
      end
      if (if_ack) begin
        n_checks++;
        if (!if_pend || if_rdata !== ref_mem[if_cur]) begin
          n_fail++; $display("FAIL rnd_if_data: cycle %0d pend=%b got %h expected %h", cyc, if_pend, if_rdata, ref_mem[if_cur]);
        end
        if_pend = 0; if_ackd = 1; if_done++;
      end
      if (dm_ack) begin
        n_checks++;
        if (!dm_pend) begin
          n_fail++; $display("FAIL rnd_dm_spurious: cycle %0d got ack expected none", cyc);
        end else if (dm_cur_we) begin
          ref_mem[dm_cur] = dm_cur_wdata;
          if (dm_rdata !== prev_dm_rdata) begin
            n_fail++; $display("FAIL rnd_store_hold: cycle %0d got %h expected %h", cyc, dm_rdata, prev_dm_rdata);
          end
        end else if (dm_rdata !== ref_mem[dm_cur]) begin
          n_fail++; $display("FAIL rnd_load_data: cycle %0d got %h expected %h", cyc, dm_rdata, ref_mem[dm_cur]);
        end
        dm_pend = 0; dm_ackd = 1; dm_done++;
      end
      if (mem_req && !prev_req) begin
        m_if = if_pend && !mem_we && mem_addr == if_cur;
        m_dm = dm_pend && mem_addr == dm_cur && mem_we == dm_cur_we && (!dm_cur_we || mem_wdata == dm_cur_wdata);
        n_checks++;
        if (!(m_if || m_dm)) begin
          n_fail++; $display("FAIL rnd_mem_start: cycle %0d got addr=%h we=%b expected a pending request", cyc, mem_addr, mem_we);
        end
      end else if (mem_req && prev_req && !prev_ready) begin
        n_checks++;
        if (mem_addr !== prev_addr) begin
          n_fail++; $display("FAIL rnd_mem_stable: cycle %0d got %h expected %h", cyc, mem_addr, prev_addr);
        end
      end
      prev_req = mem_req; prev_ready = mem_ready; prev_addr = mem_addr; prev_dm_rdata = dm_rdata;
      if (if_pend && ++if_age > 60) begin
        n_checks++; n_fail++; $display("FAIL rnd_if_timeout: cycle %0d got no ack expected one", cyc);
        if_pend = 0; if_req = 0;
      end
      if (dm_pend && ++dm_age > 60) begin
        n_checks++; n_fail++; $display("FAIL rnd_dm_timeout: cycle %0d got no ack expected one", cyc);
        dm_pend = 0; dm_req = 0;
      end
      if (cyc < 1200 && !if_pend && !if_ackd && $urandom_range(0, 2) == 0) begin
        if_cur = AW'($urandom_range(0, 15)); if_addr = if_cur; if_req = 1; if_pend = 1; if_age = 0;
      end
      if (cyc < 1200 && !dm_pend && !dm_ackd && $urandom_range(0, 2) == 0) begin
        dm_cur = AW'($urandom_range(0, 15)); dm_cur_we = 1'($urandom_range(0, 1)); dm_cur_wdata = $urandom;
        dm_addr = dm_cur; dm_we = dm_cur_we; dm_wdata = dm_cur_wdata; dm_req = 1; dm_pend = 1; dm_age = 0;
      end
    end
    n_checks++;
    if (if_done < 20 || dm_done < 20 || if_pend || dm_pend) begin
      n_fail++; $display("FAIL rnd_progress: got if=%0d dm=%0d pending=%b%b expected >=20 each, none pending",
                         if_done, dm_done, if_pend, dm_pend);
    end
    if_req = 0; dm_req = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_starvation();
    test_flush();
    test_wait_states();
    test_stray_ready();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
